matmul_core: RTL and testbench

- Parametrised matrix-multiply engine: computes C = A x B for configurable M x K by K x N unsigned matrices held in one shared single-port data memory.
- Successor to the fixed 8-bit register-file processor datapath. Replaces instruction-driven sequencing with a hardwired FSM plus multiply-accumulate datapath.
- Adds configurable widths and dimensions, a saturating/wrapping accumulate mode, overflow reporting and a start/done handshake.
- Sits between the host/controller and data memory; owns the memory port while busy.

---
 rtl/matmul_core_if.sv | 23 ++
 rtl/matmul_core.sv | 183 ++++++++++++++++++
 tb/tb_matmul_core.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_core_if.sv
// Memory-side port of matmul_core: one shared single-port data memory.
// Read data returns one cycle after the read strobe.
interface matmul_core_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_wr_en;
  logic [ACC_W-1:0]  mem_wr_data;

  modport master (
    output mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
    input  mem_rd_data
  );

  modport slave (
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/matmul_core.sv
// Matrix-multiply engine: C = A x B over a shared single-port memory, one MAC per
// element pair, with saturating or wrapping accumulation and sticky status flags.
module matmul_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DIM_W  = 8,
  parameter bit          SAT    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  dim_m,
  input  logic [DIM_W-1:0]  dim_k,
  input  logic [DIM_W-1:0]  dim_n,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  matmul_core_if.master     mem,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              cfg_err
);
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = ACC_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_A, S_FETCH_B, S_MAC, S_WRITE, S_DONE
  } state_t;

  state_t state_q, state_nx;

  logic [DIM_W-1:0]  dm_q, dk_q, dn_q, dm_nx, dk_nx, dn_nx;
  logic [ADDR_W-1:0] ba_q, bb_q, bc_q, ba_nx, bb_nx, bc_nx;
  logic [DIM_W-1:0]  i_q, j_q, k_q, i_nx, j_nx, k_nx;
  logic [ACC_W-1:0]  acc_q, acc_nx;
  logic [DATA_W-1:0] a_q, a_nx;
  logic              ovf_q, ovf_nx, cerr_q, cerr_nx;

  logic              zero_dim, last_i, last_j, last_k;
  logic [PROD_W-1:0] prod;
  logic [SUM_W-1:0]  sum;

  assign zero_dim = (dim_m == '0) || (dim_k == '0) || (dim_n == '0);
  assign last_i   = (i_q == dm_q - DIM_W'(1));
  assign last_j   = (j_q == dn_q - DIM_W'(1));
  assign last_k   = (k_q == dk_q - DIM_W'(1));
  assign prod     = PROD_W'(a_q) * PROD_W'(mem.mem_rd_data);
  assign sum      = SUM_W'(acc_q) + SUM_W'(prod);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE:    if (start) state_nx = zero_dim ? S_DONE : S_FETCH_A;
      S_FETCH_A: state_nx = S_FETCH_B;
      S_FETCH_B: state_nx = S_MAC;
      S_MAC:     state_nx = last_k ? S_WRITE : S_FETCH_A;
      S_WRITE:   state_nx = (last_i && last_j) ? S_DONE : S_FETCH_A;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Datapath next values: job latch, loop counters, accumulator, flags
  always_comb begin
    dm_nx = dm_q; dk_nx = dk_q; dn_nx = dn_q;
    ba_nx = ba_q; bb_nx = bb_q; bc_nx = bc_q;
    i_nx = i_q; j_nx = j_q; k_nx = k_q;
    acc_nx = acc_q; a_nx = a_q;
    ovf_nx = ovf_q; cerr_nx = cerr_q;
    case (state_q)
      S_IDLE: if (start) begin
        dm_nx = dim_m; dk_nx = dim_k; dn_nx = dim_n;
        ba_nx = base_a; bb_nx = base_b; bc_nx = base_c;
        i_nx = '0; j_nx = '0; k_nx = '0; acc_nx = '0;
        ovf_nx = 1'b0;
        cerr_nx = zero_dim;
      end
      S_FETCH_B: a_nx = mem.mem_rd_data;
      S_MAC: begin
        if (sum[ACC_W]) begin
          ovf_nx = 1'b1;
          acc_nx = SAT ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
        end else begin
          acc_nx = sum[ACC_W-1:0];
        end
        if (!last_k) k_nx = k_q + DIM_W'(1);
      end
      S_WRITE: begin
        acc_nx = '0;
        k_nx   = '0;
        if (!last_j) begin
          j_nx = j_q + DIM_W'(1);
        end else if (!last_i) begin
          j_nx = '0;
          i_nx = i_q + DIM_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_q <= '0; dk_q <= '0; dn_q <= '0;
      ba_q <= '0; bb_q <= '0; bc_q <= '0;
      i_q <= '0; j_q <= '0; k_q <= '0;
      acc_q <= '0; a_q <= '0;
      ovf_q <= 1'b0; cerr_q <= 1'b0;
    end else begin
      dm_q <= dm_nx; dk_q <= dk_nx; dn_q <= dn_nx;
      ba_q <= ba_nx; bb_q <= bb_nx; bc_q <= bc_nx;
      i_q <= i_nx; j_q <= j_nx; k_q <= k_nx;
      acc_q <= acc_nx; a_q <= a_nx;
      ovf_q <= ovf_nx; cerr_q <= cerr_nx;
    end
  end

  // Outputs are decoded from the upcoming state so they register in step with it
  logic [ADDR_W-1:0] addr_d;
  logic [ACC_W-1:0]  wdata_d;
  logic              rd_d, wr_d, busy_d, done_d;

  always_comb begin
    addr_d  = '0;
    wdata_d = '0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_nx)
      S_FETCH_A: begin
        rd_d   = 1'b1;
        busy_d = 1'b1;
        addr_d = ba_nx + ADDR_W'(i_nx) * ADDR_W'(dk_nx) + ADDR_W'(k_nx);
      end
      S_FETCH_B: begin
        rd_d   = 1'b1;
        busy_d = 1'b1;
        addr_d = bb_nx + ADDR_W'(k_nx) * ADDR_W'(dn_nx) + ADDR_W'(j_nx);
      end
      S_MAC: busy_d = 1'b1;
      S_WRITE: begin
        wr_d    = 1'b1;
        busy_d  = 1'b1;
        addr_d  = bc_nx + ADDR_W'(i_nx) * ADDR_W'(dn_nx) + ADDR_W'(j_nx);
        wdata_d = acc_nx;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem.mem_addr    <= '0;
      mem.mem_rd_en   <= 1'b0;
      mem.mem_wr_en   <= 1'b0;
      mem.mem_wr_data <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      mem.mem_addr    <= addr_d;
      mem.mem_rd_en   <= rd_d;
      mem.mem_wr_en   <= wr_d;
      mem.mem_wr_data <= wdata_d;
      busy            <= busy_d;
      done            <= done_d;
    end
  end

  assign overflow = ovf_q;
  assign cfg_err  = cerr_q;

endmodule

// File: tb/tb_matmul_core.sv
// Scoreboard bench for matmul_core: a saturating and a wrapping instance share one
// memory model; expected C writes are queued by the stimulus and popped by a monitor.
module tb_matmul_core;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DIM_W  = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic start_s, start_w;
  logic [DIM_W-1:0]  dim_m, dim_k, dim_n;
  logic [ADDR_W-1:0] base_a, base_b, base_c;
  logic busy_s, done_s, ovf_s, cerr_s;
  logic busy_w, done_w, ovf_w, cerr_w;

  always #5 clk = ~clk;

  matmul_core_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus_s ();
  matmul_core_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus_w ();

  matmul_core #(.DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .SAT(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s),
    .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
    .base_a(base_a), .base_b(base_b), .base_c(base_c),
    .mem(bus_s.master),
    .busy(busy_s), .done(done_s), .overflow(ovf_s), .cfg_err(cerr_s)
  );

  matmul_core #(.DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start_w),
    .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
    .base_a(base_a), .base_b(base_b), .base_c(base_c),
    .mem(bus_w.master),
    .busy(busy_w), .done(done_w), .overflow(ovf_w), .cfg_err(cerr_w)
  );

  logic [DATA_W-1:0] mem [0:65535];

  always @(posedge clk) begin
    bus_s.mem_rd_data <= mem[bus_s.mem_addr];
    bus_w.mem_rd_data <= mem[bus_w.mem_addr];
  end

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [ACC_W-1:0]  data;
  } wr_t;

  wr_t               exp_q[$];
  logic [ADDR_W-1:0] rd_log[$];
  int checks   = 0;
  int failures = 0;
  int strobe_cnt = 0;
  int done_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_write(input string who, input logic [ADDR_W-1:0] a, input logic [ACC_W-1:0] d);
    wr_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_unexpected_write: got addr 0x%0h data %0d expected no write", who, a, d);
    end else begin
      e = exp_q.pop_front();
      check({who, "_wr_addr"}, 32'(a), 32'(e.addr));
      check({who, "_wr_data"}, 32'(d), 32'(e.data));
    end
  endtask

  // Monitor: scoreboard pops on every write, bus sanity on every cycle
  always @(negedge clk) begin
    if (bus_s.mem_wr_en) sb_write("sat", bus_s.mem_addr, bus_s.mem_wr_data);
    if (bus_w.mem_wr_en) sb_write("wrap", bus_w.mem_addr, bus_w.mem_wr_data);
    if (bus_s.mem_rd_en) rd_log.push_back(bus_s.mem_addr);
    if (bus_w.mem_rd_en) rd_log.push_back(bus_w.mem_addr);
    if (bus_s.mem_rd_en || bus_s.mem_wr_en || bus_w.mem_rd_en || bus_w.mem_wr_en) strobe_cnt++;
    if (bus_s.mem_rd_en || bus_s.mem_wr_en)
      check("sat_strobe_excl", 32'(bus_s.mem_rd_en & bus_s.mem_wr_en), 32'd0);
    else
      check("sat_idle_bus", {bus_s.mem_addr, bus_s.mem_wr_data}, 32'd0);
    if (!(bus_w.mem_rd_en || bus_w.mem_wr_en))
      check("wrap_idle_bus", {bus_w.mem_addr, bus_w.mem_wr_data}, 32'd0);
    if (done_s || done_w) done_cnt++;
  end

  task automatic set_job(input int m, input int k, input int n,
                         input int ba, input int bb, input int bc);
    dim_m = DIM_W'(m); dim_k = DIM_W'(k); dim_n = DIM_W'(n);
    base_a = ADDR_W'(ba); base_b = ADDR_W'(bb); base_c = ADDR_W'(bc);
  endtask

  task automatic push_exp(input int a, input int d);
    wr_t e;
    e.addr = ADDR_W'(a);
    e.data = ACC_W'(d);
    exp_q.push_back(e);
  endtask

  // Issue start with the DUT idle, then measure cycles until the done pulse
  task automatic run_job(input string name, input bit wrap, input int exp_lat, input bit hold);
    int lat;
    @(negedge clk);
    if (wrap) start_w = 1'b1; else start_s = 1'b1;
    @(negedge clk);
    if (!hold) begin start_s = 1'b0; start_w = 1'b0; end
    lat = 1;
    while (!(wrap ? done_w : done_s) && lat < 4000) begin
      @(negedge clk);
      lat++;
    end
    start_s = 1'b0;
    start_w = 1'b0;
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_busy_at_done"}, 32'(wrap ? busy_w : busy_s), 32'd0);
    @(negedge clk);
    check({name, "_done_one_cycle"}, 32'(wrap ? done_w : done_s), 32'd0);
    check({name, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int dc;
    start_s = 1'b0;
    start_w = 1'b0;
    set_job(0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 65536; a++) mem[a] = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_s), 32'd0);
    check("rst_done", 32'(done_s), 32'd0);
    check("rst_flags", {30'd0, ovf_s, cerr_s}, 32'd0);
    check("rst_strobes", {30'd0, bus_s.mem_rd_en, bus_s.mem_wr_en}, 32'd0);
    rst_n = 1'b1;

    // 2x2x2 directed product
    mem[16'h0000] = 8'd1; mem[16'h0001] = 8'd2; mem[16'h0002] = 8'd3; mem[16'h0003] = 8'd4;
    mem[16'h0010] = 8'd5; mem[16'h0011] = 8'd6; mem[16'h0012] = 8'd7; mem[16'h0013] = 8'd8;
    set_job(2, 2, 2, 16'h0000, 16'h0010, 16'h0020);
    push_exp(16'h0020, 19); push_exp(16'h0021, 22);
    push_exp(16'h0022, 43); push_exp(16'h0023, 50);
    run_job("mm222", 1'b0, 29, 1'b0);
    check("mm222_overflow", 32'(ovf_s), 32'd0);
    check("mm222_cfg_err", 32'(cerr_s), 32'd0);

    // Overflow: 255*255 + 255*255 = 130050
    mem[16'h0100] = 8'd255; mem[16'h0101] = 8'd255;
    mem[16'h0200] = 8'd255; mem[16'h0201] = 8'd255;
    set_job(1, 2, 1, 16'h0100, 16'h0200, 16'h0300);
    push_exp(16'h0300, 65535);
    run_job("sat", 1'b0, 8, 1'b0);
    check("sat_overflow", 32'(ovf_s), 32'd1);
    push_exp(16'h0300, 64514);
    run_job("wrap", 1'b1, 8, 1'b0);
    check("wrap_overflow", 32'(ovf_w), 32'd1);

    // Zero dimension: no memory traffic, immediate done
    set_job(2, 0, 2, 16'h0000, 16'h0010, 16'h0020);
    strobe_cnt = 0;
    run_job("zero_k", 1'b0, 1, 1'b0);
    check("zero_k_cfg_err", 32'(cerr_s), 32'd1);
    check("zero_k_strobes", 32'(strobe_cnt), 32'd0);

    // Start held high across a 1x1x3 job: one run, flags cleared
    mem[16'h0400] = 8'd1; mem[16'h0401] = 8'd2; mem[16'h0402] = 8'd3;
    mem[16'h0410] = 8'd4; mem[16'h0411] = 8'd5; mem[16'h0412] = 8'd6;
    set_job(1, 3, 1, 16'h0400, 16'h0410, 16'h0420);
    push_exp(16'h0420, 32);
    dc = done_cnt;
    run_job("held", 1'b0, 11, 1'b1);
    repeat (20) @(negedge clk);
    check("held_single_done", 32'(done_cnt - dc), 32'd1);
    check("held_idle_after", 32'(busy_s), 32'd0);
    check("held_cfg_err_cleared", 32'(cerr_s), 32'd0);
    check("held_overflow_cleared", 32'(ovf_s), 32'd0);

    // Reset during MAC of a 2x2x2 job
    set_job(2, 2, 2, 16'h0000, 16'h0010, 16'h0020);
    @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_busy", 32'(busy_s), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy_s), 32'd0);
    check("mid_rst_strobes", {30'd0, bus_s.mem_rd_en, bus_s.mem_wr_en}, 32'd0);
    check("mid_rst_bus", {bus_s.mem_addr, bus_s.mem_wr_data}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    push_exp(16'h0020, 19); push_exp(16'h0021, 22);
    push_exp(16'h0022, 43); push_exp(16'h0023, 50);
    run_job("post_rst", 1'b0, 29, 1'b0);

    // Address wrap: A at 0xFFFF then 0x0000
    mem[16'hFFFF] = 8'd3; mem[16'h0000] = 8'd4;
    mem[16'h0500] = 8'd5; mem[16'h0501] = 8'd6;
    set_job(1, 2, 1, 16'hFFFF, 16'h0500, 16'h0510);
    push_exp(16'h0510, 39);
    rd_log.delete();
    run_job("addr_wrap", 1'b0, 8, 1'b0);
    check("addr_wrap_reads", 32'(rd_log.size()), 32'd4);
    if (rd_log.size() == 4) begin
      check("addr_wrap_rd0", 32'(rd_log[0]), 32'h0000FFFF);
      check("addr_wrap_rd1", 32'(rd_log[1]), 32'h00000500);
      check("addr_wrap_rd2", 32'(rd_log[2]), 32'h00000000);
      check("addr_wrap_rd3", 32'(rd_log[3]), 32'h00000501);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
